// File: rtl/riscv_pkg.sv
// Shared RV32M multiply/divide definitions: funct3 codes, FSM states,
// iteration count and the sign/half-select finishing function.
package riscv_pkg;

  localparam int MULDIV_ITER = 32;

  localparam logic [2:0] MULDIV_MUL    = 3'd0;
  localparam logic [2:0] MULDIV_MULH   = 3'd1;
  localparam logic [2:0] MULDIV_MULHSU = 3'd2;
  localparam logic [2:0] MULDIV_MULHU  = 3'd3;
  localparam logic [2:0] MULDIV_DIV    = 3'd4;
  localparam logic [2:0] MULDIV_DIVU   = 3'd5;
  localparam logic [2:0] MULDIV_REM    = 3'd6;
  localparam logic [2:0] MULDIV_REMU   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } muldiv_state_t;

  // hi/lo is the unsigned 64-bit product, or remainder/quotient for divides
  function automatic logic [31:0] muldiv_finish(
    input logic [2:0]  op,
    input logic        neg_q,
    input logic        neg_r,
    input logic [31:0] hi,
    input logic [31:0] lo
  );
    logic [63:0] prod;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [31:0] res;
    prod = neg_q ? (64'd0 - {hi, lo}) : {hi, lo};
    quot = neg_q ? (32'd0 - lo) : lo;
    rem  = neg_r ? (32'd0 - hi) : hi;
    case (op)
      MULDIV_MUL:                             res = prod[31:0];
      MULDIV_MULH, MULDIV_MULHSU, MULDIV_MULHU: res = prod[63:32];
      MULDIV_DIV, MULDIV_DIVU:                res = quot;
      MULDIV_REM, MULDIV_REMU:                res = rem;
      default:                                res = 32'd0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/riscv_div_iter.sv
// Shared hi/lo shift-register datapath: one restoring-divide step or one
// shift-add multiply step per cycle, with the iteration counter.
module riscv_div_iter
  import riscv_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic        i_step,
  input  logic        i_mode_div,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_hi_nxt,
  output logic [31:0] o_lo_nxt,
  output logic        o_last
);

  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_b;
  logic [4:0]  r_cnt;

  logic [32:0] w_sum;
  logic [32:0] w_shift;
  logic [32:0] w_diff;

  assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : 33'd0);
  assign w_shift = {r_hi, r_lo[31]};
  assign w_diff  = w_shift - {1'b0, r_b};
  assign o_last  = (r_cnt == 5'(MULDIV_ITER - 1));

  // Divide keeps {rem, quot}; multiply keeps {accumulator, multiplier} shifting right
  always_comb begin
    o_hi_nxt = r_hi;
    o_lo_nxt = r_lo;
    if (i_mode_div) begin
      if (!w_diff[32]) begin
        o_hi_nxt = w_diff[31:0];
        o_lo_nxt = {r_lo[30:0], 1'b1};
      end else begin
        o_hi_nxt = w_shift[31:0];
        o_lo_nxt = {r_lo[30:0], 1'b0};
      end
    end else begin
      o_hi_nxt = w_sum[32:1];
      o_lo_nxt = {w_sum[0], r_lo[31:1]};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hi  <= 32'd0;
      r_lo  <= 32'd0;
      r_b   <= 32'd0;
      r_cnt <= 5'd0;
    end else if (i_load) begin
      r_hi  <= 32'd0;
      r_lo  <= i_a;
      r_b   <= i_b;
      r_cnt <= 5'd0;
    end else if (i_step) begin
      r_hi  <= o_hi_nxt;
      r_lo  <= o_lo_nxt;
      r_cnt <= r_cnt + 5'd1;
    end else begin
      r_hi  <= r_hi;
      r_lo  <= r_lo;
      r_b   <= r_b;
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for EX with stall request and flush.
// Define RISCV_MULDIV_FAST_MUL_EN for a single-cycle multiplier on ops 0-3.
module riscv_muldiv_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            iclk,
  input  logic            irst,
  input  logic            istart_ex,
  input  logic [2:0]      ifunct3_ex,
  input  logic [XLEN-1:0] isrc_a_ex,
  input  logic [XLEN-1:0] isrc_b_ex,
  input  logic            iflush_ex,
  output logic            ostall_req,
  output logic [XLEN-1:0] oresult,
  output logic            odone
);

  muldiv_state_t r_state;
  muldiv_state_t w_state_nxt;
  logic [2:0]      r_op;
  logic            r_neg_q;
  logic            r_neg_r;
  logic [XLEN-1:0] r_result;
  logic            r_done;

  logic            w_signed_a, w_signed_b, w_neg_a, w_neg_b, w_is_div;
  logic            w_div0, w_ovf, w_fast_mul, w_direct, w_load, w_step, w_last;
  logic [XLEN-1:0] w_mag_a, w_mag_b, w_hi_nxt, w_lo_nxt, w_result_nxt;
  logic [63:0]     w_fast_prod;

  assign w_signed_a = (ifunct3_ex == MULDIV_MULH) || (ifunct3_ex == MULDIV_MULHSU) ||
                      (ifunct3_ex == MULDIV_DIV)  || (ifunct3_ex == MULDIV_REM);
  assign w_signed_b = (ifunct3_ex == MULDIV_MULH) || (ifunct3_ex == MULDIV_DIV) ||
                      (ifunct3_ex == MULDIV_REM);
  assign w_neg_a  = w_signed_a & isrc_a_ex[XLEN-1];
  assign w_neg_b  = w_signed_b & isrc_b_ex[XLEN-1];
  assign w_mag_a  = w_neg_a ? ({XLEN{1'b0}} - isrc_a_ex) : isrc_a_ex;
  assign w_mag_b  = w_neg_b ? ({XLEN{1'b0}} - isrc_b_ex) : isrc_b_ex;
  assign w_is_div = ifunct3_ex[2];
  assign w_div0   = w_is_div && (isrc_b_ex == {XLEN{1'b0}});
  assign w_ovf    = ((ifunct3_ex == MULDIV_DIV) || (ifunct3_ex == MULDIV_REM)) &&
                    (isrc_a_ex == 32'h8000_0000) && (isrc_b_ex == 32'hFFFF_FFFF);

`ifdef RISCV_MULDIV_FAST_MUL_EN
  assign w_fast_mul  = ~w_is_div;
  assign w_fast_prod = {32'd0, w_mag_a} * {32'd0, w_mag_b};
`else
  assign w_fast_mul  = 1'b0;
  assign w_fast_prod = 64'd0;
`endif

  assign w_direct = w_div0 | w_ovf | w_fast_mul;
  assign w_load   = (r_state == S_IDLE) && istart_ex;
  assign w_step   = (r_state == S_MUL) || (r_state == S_DIV);

  riscv_div_iter u_iter (
    .i_clk      (iclk),
    .i_rst      (irst),
    .i_load     (w_load),
    .i_step     (w_step),
    .i_mode_div (r_state == S_DIV),
    .i_a        (w_mag_a),
    .i_b        (w_mag_b),
    .o_hi_nxt   (w_hi_nxt),
    .o_lo_nxt   (w_lo_nxt),
    .o_last     (w_last)
  );

  // State register
  always_ff @(posedge iclk) begin
    if (irst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; DONE always returns to IDLE so a held istart_ex is not re-run
  always_comb begin
    w_state_nxt = r_state;
    if (iflush_ex) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!istart_ex)    w_state_nxt = S_IDLE;
          else if (w_direct) w_state_nxt = S_DONE;
          else if (w_is_div) w_state_nxt = S_DIV;
          else               w_state_nxt = S_MUL;
        end
        S_MUL, S_DIV: begin
          if (w_last) w_state_nxt = S_DONE;
          else        w_state_nxt = r_state;
        end
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Stall output
  always_comb begin
    ostall_req = 1'b0;
    if (irst || iflush_ex) begin
      ostall_req = 1'b0;
    end else begin
      case (r_state)
        S_IDLE:       ostall_req = istart_ex;
        S_MUL, S_DIV: ostall_req = 1'b1;
        S_DONE:       ostall_req = 1'b0;
        default:      ostall_req = 1'b0;
      endcase
    end
  end

  // Result for the edge entering DONE: direct cases from inputs, iterative from the last step
  always_comb begin
    w_result_nxt = r_result;
    if (r_state == S_IDLE) begin
      if (w_div0)     w_result_nxt = ifunct3_ex[1] ? isrc_a_ex : 32'hFFFF_FFFF;
      else if (w_ovf) w_result_nxt = ifunct3_ex[1] ? 32'h0000_0000 : 32'h8000_0000;
      else            w_result_nxt = muldiv_finish(ifunct3_ex, w_neg_a ^ w_neg_b, w_neg_a,
                                                   w_fast_prod[63:32], w_fast_prod[31:0]);
    end else begin
      w_result_nxt = muldiv_finish(r_op, r_neg_q, r_neg_r, w_hi_nxt, w_lo_nxt);
    end
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      r_op    <= 3'd0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_load) begin
      r_op    <= ifunct3_ex;
      r_neg_q <= w_neg_a ^ w_neg_b;
      r_neg_r <= w_neg_a;
    end else begin
      r_op    <= r_op;
      r_neg_q <= r_neg_q;
      r_neg_r <= r_neg_r;
    end
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      r_result <= {XLEN{1'b0}};
      r_done   <= 1'b0;
    end else if (w_state_nxt == S_DONE && r_state != S_DONE) begin
      r_result <= w_result_nxt;
      r_done   <= 1'b1;
    end else begin
      r_result <= r_result;
      r_done   <= 1'b0;
    end
  end

  assign oresult = r_result;
  assign odone   = r_done;

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Self-checking bench for riscv_muldiv_unit against an arithmetic reference model.
module tb_riscv_muldiv_unit;

  logic        iclk = 1'b0;
  logic        irst = 1'b1;
  logic        istart_ex = 1'b0;
  logic [2:0]  ifunct3_ex = 3'd0;
  logic [31:0] isrc_a_ex = 32'd0;
  logic [31:0] isrc_b_ex = 32'd0;
  logic        iflush_ex = 1'b0;
  logic        ostall_req;
  logic [31:0] oresult;
  logic        odone;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] last_exp = 32'd0;

  riscv_muldiv_unit #(.XLEN(32)) dut (
    .iclk       (iclk),
    .irst       (irst),
    .istart_ex  (istart_ex),
    .ifunct3_ex (ifunct3_ex),
    .isrc_a_ex  (isrc_a_ex),
    .isrc_b_ex  (isrc_b_ex),
    .iflush_ex  (iflush_ex),
    .ostall_req (ostall_req),
    .oresult    (oresult),
    .odone      (odone)
  );

  always #5 iclk = ~iclk;

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ua, ub;
    int ia, ib;
    logic [63:0] p;
    logic [31:0] r;
    logic ovf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    ia = $signed(a);
    ib = $signed(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p = 64'd0;
    r = 32'd0;
    case (op)
      3'd0: begin p = ua * ub; r = p[31:0];  end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: r = (b == 32'd0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(ia / ib));
      3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 32'd0) ? a : (ovf ? 32'd0 : 32'(ia % ib));
      default: r = (b == 32'd0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    int lat;
    lat = 33;
    if (op >= 3'd4 && (b == 32'd0 || ((op == 3'd4 || op == 3'd6) &&
        a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      lat = 1;
`ifdef RISCV_MULDIV_FAST_MUL_EN
    if (op < 3'd4) lat = 1;
`endif
    return lat;
  endfunction

  // Issues one op at the next falling edge; returns result, done latency (-1 on timeout),
  // cycles with stall high before done, and stall during the done cycle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int nstall,
                        output logic stall_at_done);
    @(negedge iclk);
    istart_ex = 1'b1; ifunct3_ex = op; isrc_a_ex = a; isrc_b_ex = b;
    res = 32'd0; lat = -1; nstall = 0; stall_at_done = 1'b0;
    for (int k = 0; k < 80; k++) begin
      #1;
      if (odone) begin
        lat = k; res = oresult; stall_at_done = ostall_req;
        break;
      end
      if (ostall_req) nstall++;
      @(negedge iclk);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge iclk);
      istart_ex = 1'b0;
    end
  endtask

  task automatic test_reset();
    @(negedge iclk);
    irst = 1'b1; istart_ex = 1'b1; ifunct3_ex = 3'd4; isrc_a_ex = 32'd9; isrc_b_ex = 32'd2;
    @(negedge iclk);
    @(negedge iclk);
    #1;
    n_checks++;
    if (oresult !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h want 0", oresult); end
    n_checks++;
    if (odone !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", odone); end
    n_checks++;
    if (ostall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", ostall_req); end
    @(negedge iclk);
    irst = 1'b0; istart_ex = 1'b0;
  endtask

  task automatic test_directed();
    logic [2:0]  d_op [10];
    logic [31:0] d_a  [10];
    logic [31:0] d_b  [10];
    logic [31:0] d_r  [10];
    logic [31:0] res;
    int lat, nstall, elat;
    logic sdone;
    d_op = '{3'd0, 3'd1, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd2, 3'd3};
    d_a  = '{32'd7, 32'h8000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd5, 32'd5,
             32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    d_b  = '{32'hFFFF_FFFD, 32'h8000_0000, 32'd2, 32'd2, 32'd0, 32'd0,
             32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF};
    d_r  = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
             32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    for (int i = 0; i < 10; i++) begin
      elat = ref_latency(d_op[i], d_a[i], d_b[i]);
      run_op(d_op[i], d_a[i], d_b[i], res, lat, nstall, sdone);
      n_checks++;
      if (res !== d_r[i]) begin
        n_fail++; $display("FAIL directed_result[%0d]: got %h want %h", i, res, d_r[i]);
      end
      n_checks++;
      if (lat != elat) begin
        n_fail++; $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, elat);
      end
      n_checks++;
      if (nstall != elat || sdone !== 1'b0) begin
        n_fail++;
        $display("FAIL directed_stall[%0d]: got %0d cycles (done-cycle %b) want %0d (0)",
                 i, nstall, sdone, elat);
      end
      last_exp = d_r[i];
      idle(2);
    end
  endtask

  task automatic test_flush();
    int done_at;
    logic [31:0] res;
    @(negedge iclk);
    istart_ex = 1'b1; ifunct3_ex = 3'd4; isrc_a_ex = 32'd1000; isrc_b_ex = 32'd3;
    repeat (9) @(negedge iclk);
    #1;
    n_checks++;
    if (ostall_req !== 1'b1) begin n_fail++; $display("FAIL flush_pre_stall: got %b want 1", ostall_req); end
    @(negedge iclk);
    iflush_ex = 1'b1; istart_ex = 1'b0;
    #1;
    n_checks++;
    if (ostall_req !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b want 0", ostall_req); end
    @(negedge iclk);
    iflush_ex = 1'b0;
    #1;
    n_checks++;
    if (odone !== 1'b0 || oresult !== last_exp) begin
      n_fail++; $display("FAIL flush_hold: done %b result %h want 0 %h", odone, oresult, last_exp);
    end
    @(negedge iclk);
    istart_ex = 1'b1; ifunct3_ex = 3'd5; isrc_a_ex = 32'd100; isrc_b_ex = 32'd7;
    done_at = -1; res = 32'd0;
    for (int k = 12; k < 90; k++) begin
      #1;
      if (odone) begin done_at = k; res = oresult; break; end
      @(negedge iclk);
    end
    n_checks++;
    if (done_at != 45) begin n_fail++; $display("FAIL flush_reissue_time: got T+%0d want T+45", done_at); end
    n_checks++;
    if (res !== 32'd14) begin n_fail++; $display("FAIL flush_reissue_result: got %h want 0000000e", res); end
    last_exp = 32'd14;
    idle(2);
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    int lat, nstall;
    logic sdone;
    @(negedge iclk);
    istart_ex = 1'b1; ifunct3_ex = 3'd4; isrc_a_ex = 32'hFFFF_FFF9; isrc_b_ex = 32'd2;
    repeat (5) @(negedge iclk);
    irst = 1'b1; istart_ex = 1'b0;
    #1;
    n_checks++;
    if (ostall_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_stall_in_reset: got %b want 0", ostall_req); end
    @(negedge iclk);
    irst = 1'b0;
    #1;
    n_checks++;
    if (oresult !== 32'd0 || odone !== 1'b0 || ostall_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: result %h done %b stall %b want 0 0 0", oresult, odone, ostall_req);
    end
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, res, lat, nstall, sdone);
    n_checks++;
    if (res !== 32'hFFFF_FFFF || lat != 33) begin
      n_fail++; $display("FAIL rstmid_next_op: got %h lat %0d want ffffffff lat 33", res, lat);
    end
    idle(2);
  endtask

  task automatic test_random(input int n, input bit b2b);
    logic [2:0]  op;
    logic [31:0] a, b, res, exp;
    int lat, nstall, elat, sel;
    logic sdone;
    for (int i = 0; i < n; i++) begin
      op = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 5);
      a = $urandom;
      b = $urandom;
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
      else if (sel == 3) b = 32'(0 - $urandom_range(1, 20));
      exp  = ref_result(op, a, b);
      elat = ref_latency(op, a, b);
      run_op(op, a, b, res, lat, nstall, sdone);
      n_checks++;
      if (res !== exp) begin
        n_fail++; $display("FAIL rand_result[%0d] op%0d %h,%h: got %h want %h", i, op, a, b, res, exp);
      end
      n_checks++;
      if (lat != elat) begin
        n_fail++; $display("FAIL rand_latency[%0d] op%0d: got %0d want %0d", i, op, lat, elat);
      end
      n_checks++;
      if (nstall != elat || sdone !== 1'b0) begin
        n_fail++; $display("FAIL rand_stall[%0d]: got %0d (done-cycle %b) want %0d (0)", i, nstall, sdone, elat);
      end
      if (!b2b) idle($urandom_range(0, 2));
    end
    idle(2);
  endtask

  task automatic test_back_to_back();
    test_random(6, 1'b1);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_flush();
    test_reset_mid();
    test_random(30, 1'b0);
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
